// File: rtl/cc_pkg.sv
// Shared widths and request/response types for the cache tag lookup stage.
package cc_pkg;

    localparam int TAG_W  = 17;
    localparam int IDX_W  = 9;
    localparam int OFF_W  = 6;
    localparam int LINE_W = 512;
    localparam int SETS   = 1 << IDX_W;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [IDX_W-1:0] index;
        logic [OFF_W-1:0] offset;
    } req_t;

    typedef struct packed {
        logic [LINE_W-1:0] line;
        logic [OFF_W-1:0]  offset;
    } hit_data_t;

endpackage

// File: rtl/cc_valid_array.sv
// Per-set valid bits: set by line fills, cleared only by reset, read combinationally.
module cc_valid_array
    import cc_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             set_en,
    input  logic [IDX_W-1:0] set_idx,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_valid
);

    logic [SETS-1:0] valid_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            valid_q <= '0;
        else if (set_en)
            valid_q[set_idx] <= 1'b1;
    end

    assign rd_valid = valid_q[rd_idx];

endmodule

// File: rtl/cc_tag_lookup.sv
// Non-stalling 3-stage tag lookup: S0 reads tags, S1 decides hit/miss and
// pushes flag/miss FIFOs, S2 pushes the hit line. Fills update tags and valid bits.
module cc_tag_lookup
    import cc_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    hs_pulse_i,
    input  logic [TAG_W-1:0]        tag_i,
    input  logic [IDX_W-1:0]        index_i,
    input  logic [OFF_W-1:0]        offset_i,
    output logic                    tag_rden_o,
    output logic [IDX_W-1:0]        tag_raddr_o,
    input  logic [TAG_W-1:0]        tag_rdata_i,
    output logic                    tag_wren_o,
    output logic [IDX_W-1:0]        tag_waddr_o,
    output logic [TAG_W-1:0]        tag_wdata_o,
    output logic                    data_rden_o,
    output logic [IDX_W-1:0]        data_raddr_o,
    input  logic [LINE_W-1:0]       data_rdata_i,
    input  logic                    fill_valid_i,
    input  logic [IDX_W-1:0]        fill_index_i,
    input  logic [TAG_W-1:0]        fill_tag_i,
    output logic                    hit_flag_fifo_wren_o,
    output logic                    hit_flag_fifo_wdata_o,
    output logic                    hit_data_fifo_wren_o,
    output logic [LINE_W+OFF_W-1:0] hit_data_fifo_wdata_o,
    output logic                    miss_addr_fifo_wren_o,
    output logic [31:0]             miss_addr_fifo_wdata_o,
    output logic                    miss_req_fifo_wren_o,
    output logic [31:0]             miss_req_fifo_wdata_o
);

    if (TAG_W + IDX_W + OFF_W != 32) begin : g_width_chk
        $error("cc_tag_lookup: TAG_W+IDX_W+OFF_W must equal 32");
    end

    logic             req_en, fill_en;
    logic [2:1]       vld_pipe;
    req_t             s1_req;
    logic             s1_byp;
    logic [TAG_W-1:0] s1_byp_tag;
    logic [OFF_W-1:0] s2_off;
    logic             s1_vbit, cmp_valid, hit, miss;
    logic [TAG_W-1:0] cmp_tag;
    hit_data_t        hit_data;

    // Inputs seen while reset is high must not reach the SRAMs or outputs.
    assign req_en  = hs_pulse_i & ~rst;
    assign fill_en = fill_valid_i & ~rst;

    assign tag_rden_o  = req_en;
    assign tag_raddr_o = req_en ? index_i : '0;
    assign tag_wren_o  = fill_en;
    assign tag_waddr_o = fill_en ? fill_index_i : '0;
    assign tag_wdata_o = fill_en ? fill_tag_i : '0;

    cc_valid_array u_valid (
        .clk      (clk),
        .rst      (rst),
        .set_en   (fill_en),
        .set_idx  (fill_index_i),
        .rd_idx   (s1_req.index),
        .rd_valid (s1_vbit)
    );

    // The newest fill to this set wins: this cycle's fill, then the one
    // captured alongside the request, then the SRAM/valid-array contents.
    always_comb begin
        cmp_tag   = tag_rdata_i;
        cmp_valid = s1_vbit;
        if (s1_byp) begin
            cmp_tag   = s1_byp_tag;
            cmp_valid = 1'b1;
        end
        if (fill_en && fill_index_i == s1_req.index) begin
            cmp_tag   = fill_tag_i;
            cmp_valid = 1'b1;
        end
        hit  = vld_pipe[1] & cmp_valid & (cmp_tag == s1_req.tag);
        miss = vld_pipe[1] & ~hit;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe   <= '0;
            s1_req     <= '0;
            s1_byp     <= 1'b0;
            s1_byp_tag <= '0;
            s2_off     <= '0;
        end else begin
            vld_pipe[1] <= req_en;
            vld_pipe[2] <= hit;
            if (req_en) begin
                s1_req     <= '{tag: tag_i, index: index_i, offset: offset_i};
                s1_byp     <= fill_en && (fill_index_i == index_i);
                s1_byp_tag <= fill_tag_i;
            end
            if (hit)
                s2_off <= s1_req.offset;
        end
    end

    assign hit_flag_fifo_wren_o   = vld_pipe[1];
    assign hit_flag_fifo_wdata_o  = hit;
    assign miss_addr_fifo_wren_o  = miss;
    assign miss_addr_fifo_wdata_o = miss ? s1_req : '0;
    assign miss_req_fifo_wren_o   = miss;
    assign miss_req_fifo_wdata_o  = miss ? {s1_req.tag, s1_req.index, {OFF_W{1'b0}}} : '0;
    assign data_rden_o            = hit;
    assign data_raddr_o           = hit ? s1_req.index : '0;

    assign hit_data              = '{line: data_rdata_i, offset: s2_off};
    assign hit_data_fifo_wren_o  = vld_pipe[2];
    assign hit_data_fifo_wdata_o = vld_pipe[2] ? hit_data : '0;

endmodule

// File: tb/tb_cc_tag_lookup.sv
// Scoreboard bench for cc_tag_lookup: a set-level cache model predicts every
// FIFO push and its cycle; a negedge monitor pops and compares.
module tb_cc_tag_lookup;
    import cc_pkg::*;

    localparam int HW = LINE_W + OFF_W;
    typedef logic [HW-1:0] wide_t;
    typedef struct { int cyc; wide_t v; } exp_t;

    logic                clk = 1'b0, rst = 1'b1;
    logic                hs_pulse_i = 1'b0, fill_valid_i = 1'b0;
    logic [TAG_W-1:0]    tag_i = '0, fill_tag_i = '0, tag_rdata_i = '0, tag_wdata_o;
    logic [IDX_W-1:0]    index_i = '0, fill_index_i = '0;
    logic [IDX_W-1:0]    tag_raddr_o, tag_waddr_o, data_raddr_o;
    logic [OFF_W-1:0]    offset_i = '0;
    logic [LINE_W-1:0]   data_rdata_i = '0;
    logic                tag_rden_o, tag_wren_o, data_rden_o;
    logic                hit_flag_fifo_wren_o, hit_flag_fifo_wdata_o, hit_data_fifo_wren_o;
    logic [HW-1:0]       hit_data_fifo_wdata_o;
    logic                miss_addr_fifo_wren_o, miss_req_fifo_wren_o;
    logic [31:0]         miss_addr_fifo_wdata_o, miss_req_fifo_wdata_o;

    cc_tag_lookup dut (
        .clk(clk), .rst(rst), .hs_pulse_i(hs_pulse_i), .tag_i(tag_i), .index_i(index_i),
        .offset_i(offset_i), .tag_rden_o(tag_rden_o), .tag_raddr_o(tag_raddr_o),
        .tag_rdata_i(tag_rdata_i), .tag_wren_o(tag_wren_o), .tag_waddr_o(tag_waddr_o),
        .tag_wdata_o(tag_wdata_o), .data_rden_o(data_rden_o), .data_raddr_o(data_raddr_o),
        .data_rdata_i(data_rdata_i), .fill_valid_i(fill_valid_i), .fill_index_i(fill_index_i),
        .fill_tag_i(fill_tag_i), .hit_flag_fifo_wren_o(hit_flag_fifo_wren_o),
        .hit_flag_fifo_wdata_o(hit_flag_fifo_wdata_o), .hit_data_fifo_wren_o(hit_data_fifo_wren_o),
        .hit_data_fifo_wdata_o(hit_data_fifo_wdata_o), .miss_addr_fifo_wren_o(miss_addr_fifo_wren_o),
        .miss_addr_fifo_wdata_o(miss_addr_fifo_wdata_o), .miss_req_fifo_wren_o(miss_req_fifo_wren_o),
        .miss_req_fifo_wdata_o(miss_req_fifo_wdata_o)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0, cyc = 0;
    int push_cnt [4];
    exp_t q [4][$];   // 0 flag, 1 miss addr, 2 miss req, 3 hit data

    // Reference cache state: tag and valid per set, fills applied in order.
    logic [TAG_W-1:0] m_tag [SETS];
    bit               m_valid [SETS];
    bit               p_vld = 1'b0;
    logic [TAG_W-1:0] p_tag;
    logic [IDX_W-1:0] p_idx;
    logic [OFF_W-1:0] p_off;

    // Environment SRAMs: 1-cycle read latency, read returns pre-write contents.
    logic [TAG_W-1:0] tag_mem [SETS];

    function automatic logic [LINE_W-1:0] line_of(input logic [IDX_W-1:0] i);
        logic [LINE_W-1:0] r;
        for (int k = 0; k < 16; k++) r[k*32 +: 32] = {8'hC5, 8'(k), 7'h0, i};
        return r;
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (tag_rden_o) tag_rdata_i <= tag_mem[tag_raddr_o];
        if (tag_wren_o) tag_mem[tag_waddr_o] <= tag_wdata_o;
        data_rdata_i <= data_rden_o ? line_of(data_raddr_o) : {16{$urandom}};
    end

    task automatic chk(input string name, input wide_t act, input wide_t exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic mon(input int k, input bit wren, input wide_t act, input string name);
        exp_t e;
        if (wren) begin
            push_cnt[k]++;
            if (q[k].size() == 0) begin
                chk({name, "_unexpected_push"}, 1, 0);
            end else begin
                e = q[k].pop_front();
                chk(name, act, e.v);
                chk({name, "_cycle"}, wide_t'(cyc), wide_t'(e.cyc));
            end
        end else if (q[k].size() > 0 && q[k][0].cyc <= cyc) begin
            e = q[k].pop_front();
            chk({name, "_missing_push"}, 0, 1);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            mon(0, hit_flag_fifo_wren_o,
                wide_t'({data_rden_o, data_raddr_o, hit_flag_fifo_wdata_o}), "hit_flag");
            mon(1, miss_addr_fifo_wren_o, wide_t'(miss_addr_fifo_wdata_o), "miss_addr");
            mon(2, miss_req_fifo_wren_o, wide_t'(miss_req_fifo_wdata_o), "miss_req");
            mon(3, hit_data_fifo_wren_o, hit_data_fifo_wdata_o, "hit_data");
            if (!hit_flag_fifo_wren_o && data_rden_o) chk("data_rden_idle", 1, 0);
        end
    end

    // One clock of stimulus; the request of the previous cycle is resolved
    // against the model after this cycle's fill, since that fill is bypassed.
    task automatic step(input bit req, input logic [TAG_W-1:0] t, input logic [IDX_W-1:0] i,
                        input logic [OFF_W-1:0] o, input bit fill,
                        input logic [TAG_W-1:0] ft, input logic [IDX_W-1:0] fi);
        bit   hit;
        exp_t e;
        @(posedge clk); #1;
        hs_pulse_i = req; tag_i = t; index_i = i; offset_i = o;
        fill_valid_i = fill; fill_tag_i = ft; fill_index_i = fi;
        if (fill) begin m_tag[fi] = ft; m_valid[fi] = 1'b1; end
        if (p_vld) begin
            hit = m_valid[p_idx] && (m_tag[p_idx] == p_tag);
            e.cyc = cyc; e.v = wide_t'({hit, hit ? p_idx : 9'h0, hit}); q[0].push_back(e);
            if (hit) begin
                e.cyc = cyc + 1; e.v = {line_of(p_idx), p_off}; q[3].push_back(e);
            end else begin
                e.cyc = cyc; e.v = wide_t'({p_tag, p_idx, p_off}); q[1].push_back(e);
                e.v = wide_t'({p_tag, p_idx, 6'h0}); q[2].push_back(e);
            end
        end
        p_vld = req; p_tag = t; p_idx = i; p_off = o;
        #1;
        chk("tag_read_port", wide_t'({tag_rden_o, tag_raddr_o}), wide_t'({req, req ? i : 9'h0}));
        chk("tag_write_port", wide_t'({tag_wren_o, tag_waddr_o, tag_wdata_o}),
            wide_t'({fill, fill ? fi : 9'h0, fill ? ft : 17'h0}));
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, '0, '0, '0, 0, '0, '0);
    endtask

    // Reset mid-cycle with a fill on the bus that must be ignored.
    task automatic do_reset();
        @(posedge clk); #2;
        hs_pulse_i = 1'b0; fill_valid_i = 1'b1; fill_index_i = 9'd5; fill_tag_i = 17'h1;
        rst = 1'b1;
        for (int k = 0; k < 4; k++) q[k].delete();
        p_vld = 1'b0;
        for (int s = 0; s < SETS; s++) m_valid[s] = 1'b0;
        #1;
        chk("reset_outputs_zero", wide_t'(|{tag_rden_o, tag_wren_o, data_rden_o, hit_flag_fifo_wren_o,
            hit_flag_fifo_wdata_o, hit_data_fifo_wren_o, hit_data_fifo_wdata_o, miss_addr_fifo_wren_o,
            miss_addr_fifo_wdata_o, miss_req_fifo_wren_o, miss_req_fifo_wdata_o, tag_raddr_o,
            tag_waddr_o, tag_wdata_o, data_raddr_o}), 0);
        repeat (2) @(posedge clk);
        #2; fill_valid_i = 1'b0; rst = 1'b0;
    endtask

    initial begin
        int c0 [4];
        for (int s = 0; s < SETS; s++) begin tag_mem[s] = '0; m_tag[s] = '0; m_valid[s] = 1'b0; end
        for (int k = 0; k < 4; k++) push_cnt[k] = 0;
        do_reset();

        // Cold lookup misses.
        step(1, 17'h1, 9'd5, 6'h2A, 0, '0, '0);
        idle(1);
        chk("cold_miss_addr", wide_t'(miss_addr_fifo_wdata_o), wide_t'(32'h0000_816A));
        chk("cold_miss_req", wide_t'(miss_req_fifo_wdata_o), wide_t'(32'h0000_8140));
        idle(1);
        // Fill then hit.
        step(0, '0, '0, '0, 1, 17'h1, 9'd5);
        step(1, 17'h1, 9'd5, 6'h3, 0, '0, '0);
        idle(1);
        chk("fill_then_hit_flag", wide_t'(hit_flag_fifo_wdata_o), 1);
        idle(1);
        // Tag mismatch.
        step(1, 17'h2, 9'd5, 6'h0, 0, '0, '0);
        idle(2);
        // Fill bypass in the request cycle.
        step(1, 17'h9, 9'd7, 6'h1, 1, 17'h9, 9'd7);
        idle(1);
        chk("bypass_s0_flag", wide_t'(hit_flag_fifo_wdata_o), 1);
        // Fill bypass in the S1 cycle.
        step(1, 17'hB, 9'd9, 6'h4, 0, '0, '0);
        step(0, '0, '0, '0, 1, 17'hB, 9'd9);
        chk("bypass_s1_flag", wide_t'(hit_flag_fifo_wdata_o), 1);
        idle(2);
        // Back-to-back alternating hit/miss.
        step(0, '0, '0, '0, 1, 17'h4, 9'd10);
        idle(1);
        for (int k = 0; k < 4; k++) c0[k] = push_cnt[k];
        step(1, 17'h4, 9'd10, 6'h5, 0, '0, '0);
        step(1, 17'h5, 9'd11, 6'h6, 0, '0, '0);
        step(1, 17'h4, 9'd10, 6'h7, 0, '0, '0);
        step(1, 17'h6, 9'd12, 6'h8, 0, '0, '0);
        idle(3);
        chk("b2b_flag_pushes", wide_t'(push_cnt[0] - c0[0]), 4);
        chk("b2b_hit_data_pushes", wide_t'(push_cnt[3] - c0[3]), 2);
        chk("b2b_miss_addr_pushes", wide_t'(push_cnt[1] - c0[1]), 2);
        chk("b2b_miss_req_pushes", wide_t'(push_cnt[2] - c0[2]), 2);
        // Reset with a hit in flight; valid bits cleared afterwards.
        step(1, 17'h1, 9'd5, 6'h3, 0, '0, '0);
        do_reset();
        step(1, 17'h1, 9'd5, 6'h3, 0, '0, '0);
        idle(1);
        chk("post_reset_miss_flag", wide_t'({hit_flag_fifo_wren_o, hit_flag_fifo_wdata_o}), 2);
        idle(2);

        // Random traffic over a few sets and tags so hits, bypasses and
        // repeated misses all occur.
        for (int n = 0; n < 1500; n++) begin
            if (n == 700) do_reset();
            step($urandom_range(0, 9) < 7, 17'($urandom_range(0, 3)), 9'($urandom_range(0, 7)),
                 6'($urandom), $urandom_range(0, 9) < 3, 17'($urandom_range(0, 3)),
                 9'($urandom_range(0, 7)));
        end
        idle(4);
        chk("scoreboard_drained", wide_t'(q[0].size() + q[1].size() + q[2].size() + q[3].size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cc_tag_lookup.md
Name: cc_tag_lookup

Overview:
- Lookup stage directly downstream of the request decoder.
- Consumes each accepted read (handshake pulse plus tag/index/offset) and reads the tag SRAM and valid bits.
- Decides hit or miss, then pushes the hit/miss FIFOs whose almost-full flags the decoder uses for back-pressure.
- Non-stalling 3-stage pipeline; also applies line fills returned by the miss path to the tag store.

Parameters:
- TAG_W, 17, tag width
- IDX_W, 9, index width (512 sets)
- OFF_W, 6, byte offset width (64 B line)
- LINE_W, 512, cache line width in bits

Ports:
- clk  in  1  single clock; all logic rising-edge
- rst  in  1  asynchronous active-high reset
- hs_pulse_i  in  1  accepted request from decoder
- tag_i  in  TAG_W  request tag
- index_i  in  IDX_W  request index
- offset_i  in  OFF_W  request offset
- tag_rden_o  out  1  tag SRAM read enable
- tag_raddr_o  out  IDX_W  tag SRAM read address
- tag_rdata_i  in  TAG_W  tag SRAM read data, 1-cycle latency
- tag_wren_o  out  1  tag SRAM write enable (separate write port)
- tag_waddr_o  out  IDX_W  tag SRAM write address
- tag_wdata_o  out  TAG_W  tag SRAM write data
- data_rden_o  out  1  data SRAM read enable
- data_raddr_o  out  IDX_W  data SRAM read address
- data_rdata_i  in  LINE_W  data SRAM read data, 1-cycle latency
- fill_valid_i  in  1  line fill completes this cycle
- fill_index_i  in  IDX_W  fill set
- fill_tag_i  in  TAG_W  fill tag
- hit_flag_fifo_wren_o  out  1  push order flag
- hit_flag_fifo_wdata_o  out  1  1 = hit, 0 = miss
- hit_data_fifo_wren_o  out  1  push hit line
- hit_data_fifo_wdata_o  out  LINE_W+OFF_W  {line, offset}
- miss_addr_fifo_wren_o  out  1  push miss address
- miss_addr_fifo_wdata_o  out  32  {tag, index, offset}
- miss_req_fifo_wren_o  out  1  push line request
- miss_req_fifo_wdata_o  out  32  {tag, index, 6'b0}

Behaviour:
- Reset:
  - All outputs 0.
  - Stage valid flags cleared; all 512 valid bits cleared.
  - In-flight requests dropped.
  - Fills arriving during reset are ignored.
- No stall:
  - Upstream back-pressure via afull guarantees FIFO space.
  - The block never checks FIFO full; one request per cycle is sustained.
- S0 (cycle of hs_pulse_i):
  - tag_rden_o=1, tag_raddr_o=index_i.
  - Register {tag, index, offset} into S1; s1_valid=1.
- S1:
  - hit = valid[idx] && (stored tag == req tag).
  - hit_flag_fifo_wren_o=1 with wdata=hit.
  - On miss: both miss FIFOs pushed in this same cycle.
  - On hit: data_rden_o=1, data_raddr_o=idx; register offset into S2.
- S2 (hit only):
  - hit_data_fifo_wren_o=1, wdata={data_rdata_i, offset}.
- Latency:
  - hit/miss flag: 1 cycle after hs_pulse_i.
  - miss FIFO pushes: 1 cycle after hs_pulse_i.
  - hit data push: 2 cycles after hs_pulse_i.
- Flag ordering: hit flags are pushed in request order; the downstream serializer relies on it.
- Fill:
  - fill_valid_i causes tag_wren_o=1, tag_waddr_o=fill_index_i, tag_wdata_o=fill_tag_i combinationally in the same cycle.
  - valid[fill_index_i] is set on the next edge.
- Bypass:
  - If a fill to index X occurs in the S0 cycle of a request to X, the SRAM returns the old tag.
  - S1 must instead compare against the registered fill tag, with valid treated as 1.
  - If the fill occurs in the S1 cycle to the same index, the compare also uses fill_tag_i/valid=1.
- Simultaneous events: fill and request in the same cycle are both serviced (dual-port tag SRAM).
- Misses: no duplicate-miss suppression; repeated misses to one line each push both miss FIFOs.
- Width rule: miss address concatenation is exactly TAG_W+IDX_W+OFF_W = 32 bits; elaboration error otherwise.

Decomposition:
- cc_pkg holds:
  - TAG_W/IDX_W/OFF_W/LINE_W localparams
  - typedef struct req_t {tag, index, offset}
  - typedef hit_data_t
- One sub-module: cc_valid_array
  - 512-bit register, async clear on rst.
  - Set port for fills; combinational read port for S1.

Test Plan:
- Post-reset lookup: hs_pulse_i with tag=0x1, idx=5 → after 1 cycle, hit_flag push wdata=0; miss_addr=0x0000_8140|off; miss_req low 6 bits 0.
- Fill then hit: fill idx=5, tag=0x1, then request idx=5, tag=0x1, off=0x3 → flag=1 at +1; hit_data push at +2 carries data_rdata_i and offset 0x3.
- Tag mismatch: after the above fill, request idx=5, tag=0x2 → miss; no data_rden_o.
- Fill bypass: fill idx=7, tag=0x9 in the same cycle as request idx=7, tag=0x9 (SRAM returns stale 0) → hit.
- Back-to-back 4 requests alternating hit/miss → flags 1,0,1,0 in order; exactly 2 hit data pushes and 2 pushes per miss FIFO.
- Reset asserted while S1/S2 valid → no FIFO push after reset; valid bits cleared, so a later request to a filled index misses.
